// File: rtl/ddr_port_arbiter_if.sv
// rtl/ddr_port_arbiter_if.sv - port-array, controller and snoop signals of the DDR port arbiter
interface ddr_port_arbiter_if #(
    parameter int NPORTS = 3
);
    // wb_port side
    logic [32*NPORTS-1:0] port_adr_i;
    logic [32*NPORTS-1:0] port_dat_i;
    logic [4*NPORTS-1:0]  port_sel_i;
    logic [NPORTS-1:0]    port_acc_i;
    logic [NPORTS-1:0]    port_we_i;
    logic [NPORTS-1:0]    port_ack_o;
    logic [31:0]          port_adr_o;
    logic [31:0]          port_dat_o;

    // controller side
    logic [31:0]          mem_adr_o;
    logic [31:0]          mem_dat_o;
    logic [3:0]           mem_sel_o;
    logic                 mem_acc_o;
    logic                 mem_we_o;
    logic                 mem_ack_i;
    logic [31:0]          mem_adr_i;
    logic [31:0]          mem_dat_i;

    // write snoop broadcast and status
    logic [31:0]          bufw_adr_o;
    logic [31:0]          bufw_dat_o;
    logic [3:0]           bufw_sel_o;
    logic [NPORTS-1:0]    bufw_we_o;
    logic [NPORTS-1:0]    grant_o;

    modport slave (
        input  port_adr_i, port_dat_i, port_sel_i, port_acc_i, port_we_i,
        input  mem_ack_i, mem_adr_i, mem_dat_i,
        output port_ack_o, port_adr_o, port_dat_o,
        output mem_adr_o, mem_dat_o, mem_sel_o, mem_acc_o, mem_we_o,
        output bufw_adr_o, bufw_dat_o, bufw_sel_o, bufw_we_o, grant_o
    );

    modport master (
        output port_adr_i, port_dat_i, port_sel_i, port_acc_i, port_we_i,
        output mem_ack_i, mem_adr_i, mem_dat_i,
        input  port_ack_o, port_adr_o, port_dat_o,
        input  mem_adr_o, mem_dat_o, mem_sel_o, mem_acc_o, mem_we_o,
        input  bufw_adr_o, bufw_dat_o, bufw_sel_o, bufw_we_o, grant_o
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - round-robin whole-transaction arbiter for the shared SDRAM request port
module ddr_port_arbiter #(
    parameter int NPORTS    = 3,
    parameter int BUF_WIDTH = 3
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst_n,
    ddr_port_arbiter_if.slave bus
);
    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    if (NPORTS < 2 || NPORTS > 8 || BUF_WIDTH < 1) begin : g_param_check
        $error("ddr_port_arbiter: unsupported NPORTS or BUF_WIDTH");
    end

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     last_q, last_d;

    logic [IW-1:0]     winner;
    logic              found;

    logic [NPORTS-1:0] ack;
    logic [31:0]       mem_adr;
    logic [31:0]       mem_dat;
    logic [3:0]        mem_sel;
    logic              mem_acc;
    logic              mem_we;

    logic              snoop_hit;
    logic [NPORTS-1:0] bufw_we_q;
    logic [31:0]       bufw_adr_q;
    logic [31:0]       bufw_dat_q;
    logic [3:0]        bufw_sel_q;

    // First requester scanning upward from the port after the last winner.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= NPORTS; i++) begin
            if (!found && bus.port_acc_i[(int'(last_q) + i) % NPORTS]) begin
                winner = IW'((int'(last_q) + i) % NPORTS);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NPORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

    // Release always passes through IDLE, so no re-arbitration in the release cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    grant_d = {{(NPORTS-1){1'b0}}, 1'b1} << winner;
                    gidx_d  = winner;
                    last_d  = winner;
                end
            end
            S_GRANT: begin
                if (!bus.port_acc_i[gidx_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        ack     = '0;
        mem_adr = '0;
        mem_dat = '0;
        mem_sel = '0;
        mem_acc = 1'b0;
        mem_we  = 1'b0;
        if (state_q == S_GRANT) begin
            mem_adr      = bus.port_adr_i[32*gidx_q +: 32];
            mem_dat      = bus.port_dat_i[32*gidx_q +: 32];
            mem_sel      = bus.port_sel_i[4*gidx_q +: 4];
            mem_acc      = bus.port_acc_i[gidx_q];
            mem_we       = bus.port_we_i[gidx_q];
            ack[gidx_q]  = bus.mem_ack_i;
        end
    end

    assign snoop_hit = (state_q == S_GRANT) && bus.port_we_i[gidx_q] && bus.mem_ack_i;

    // Completed writes are replayed to every other port so their read buffers stay coherent.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            bufw_we_q  <= '0;
            bufw_adr_q <= '0;
            bufw_dat_q <= '0;
            bufw_sel_q <= '0;
        end else begin
            bufw_we_q <= snoop_hit ? ~grant_q : '0;
            if (snoop_hit) begin
                bufw_adr_q <= bus.port_adr_i[32*gidx_q +: 32];
                bufw_dat_q <= bus.port_dat_i[32*gidx_q +: 32];
                bufw_sel_q <= bus.port_sel_i[4*gidx_q +: 4];
            end
        end
    end

    assign bus.port_ack_o = ack;
    assign bus.port_adr_o = bus.mem_adr_i;
    assign bus.port_dat_o = bus.mem_dat_i;
    assign bus.mem_adr_o  = mem_adr;
    assign bus.mem_dat_o  = mem_dat;
    assign bus.mem_sel_o  = mem_sel;
    assign bus.mem_acc_o  = mem_acc;
    assign bus.mem_we_o   = mem_we;
    assign bus.bufw_we_o  = bufw_we_q;
    assign bus.bufw_adr_o = bufw_adr_q;
    assign bus.bufw_dat_o = bufw_dat_q;
    assign bus.bufw_sel_o = bufw_sel_q;
    assign bus.grant_o    = grant_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - self-checking bench for ddr_port_arbiter against a transaction-level model
module tb_ddr_port_arbiter;
    localparam int N     = 3;
    localparam int BW    = 3;
    localparam int BURST = 1 << BW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr_port_arbiter_if #(.NPORTS(N)) bus ();

    ddr_port_arbiter #(.NPORTS(N), .BUF_WIDTH(BW)) dut (
        .sdram_clk   (clk),
        .sdram_rst_n (rst_n),
        .bus         (bus)
    );

    int checks   = 0;
    int failures = 0;

    // model: which port owns the memory (-1 = none), round-robin pointer, snoop registers
    int          owner      = -1;
    int          last_p     = N - 1;
    logic [N-1:0] m_bufw_we  = '0;
    logic [31:0] m_bufw_adr = '0;
    logic [31:0] m_bufw_dat = '0;
    logic [3:0]  m_bufw_sel = '0;
    int          acks_taken [N];

    // port agents
    int  start_cnt [N];
    int  len       [N];
    int  cool      [N];
    bit  want      [N];
    int  gap_max    = 0;
    bit  agent_on   = 1'b0;
    bit  allow_drop = 1'b0;

    int           dut_log [$];
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] acc);
        for (int k = 1; k <= N; k++)
            if (acc[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= -1;
            last_p     <= N - 1;
            m_bufw_we  <= '0;
            m_bufw_adr <= '0;
            m_bufw_dat <= '0;
            m_bufw_sel <= '0;
        end else if (owner >= 0) begin
            if (bus.mem_ack_i && bus.port_acc_i[owner])
                acks_taken[owner] <= acks_taken[owner] + 1;
            if (bus.mem_ack_i && bus.port_we_i[owner]) begin
                m_bufw_we  <= ~(N'(1) << owner);
                m_bufw_adr <= bus.port_adr_i[32*owner +: 32];
                m_bufw_dat <= bus.port_dat_i[32*owner +: 32];
                m_bufw_sel <= bus.port_sel_i[4*owner +: 4];
            end else begin
                m_bufw_we <= '0;
            end
            if (!bus.port_acc_i[owner]) owner <= -1;
        end else begin
            m_bufw_we <= '0;
            if (bus.port_acc_i != '0) begin
                owner  <= rr_pick(last_p, bus.port_acc_i);
                last_p <= rr_pick(last_p, bus.port_acc_i);
            end
        end
    end

    task automatic check_outputs();
        logic [N-1:0] e_grant, e_ack;
        logic         e_acc, e_we;
        logic [31:0]  e_adr, e_dat;
        logic [3:0]   e_sel;
        e_grant = '0; e_ack = '0; e_acc = 1'b0; e_we = 1'b0;
        e_adr = '0; e_dat = '0; e_sel = '0;
        if (owner >= 0) begin
            e_grant[owner] = 1'b1;
            e_ack[owner]   = bus.mem_ack_i;
            e_acc = bus.port_acc_i[owner];
            e_we  = bus.port_we_i[owner];
            e_adr = bus.port_adr_i[32*owner +: 32];
            e_dat = bus.port_dat_i[32*owner +: 32];
            e_sel = bus.port_sel_i[4*owner +: 4];
        end
        chk("grant_o",    32'(bus.grant_o),    32'(e_grant));
        chk("port_ack_o", 32'(bus.port_ack_o), 32'(e_ack));
        chk("mem_acc_o",  32'(bus.mem_acc_o),  32'(e_acc));
        chk("mem_we_o",   32'(bus.mem_we_o),   32'(e_we));
        chk("mem_adr_o",  bus.mem_adr_o,       e_adr);
        chk("mem_dat_o",  bus.mem_dat_o,       e_dat);
        chk("mem_sel_o",  32'(bus.mem_sel_o),  32'(e_sel));
        chk("port_adr_o", bus.port_adr_o,      bus.mem_adr_i);
        chk("port_dat_o", bus.port_dat_o,      bus.mem_dat_i);
        chk("bufw_we_o",  32'(bus.bufw_we_o),  32'(m_bufw_we));
        chk("bufw_adr_o", bus.bufw_adr_o,      m_bufw_adr);
        chk("bufw_dat_o", bus.bufw_dat_o,      m_bufw_dat);
        chk("bufw_sel_o", 32'(bus.bufw_sel_o), 32'(m_bufw_sel));
        if (bus.grant_o != '0 && bus.grant_o != prev_grant)
            for (int p = 0; p < N; p++)
                if (bus.grant_o[p]) dut_log.push_back(p);
        prev_grant = bus.grant_o;
    endtask

    always @(negedge clk) begin
        #2;
        check_outputs();
    end

    task automatic agent_step();
        for (int p = 0; p < N; p++) begin
            if (bus.port_acc_i[p]) begin
                if (acks_taken[p] - start_cnt[p] >= len[p]) begin
                    bus.port_acc_i[p] = 1'b0;
                    bus.port_we_i[p]  = 1'b0;
                    cool[p] = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
                end else if (allow_drop && owner != p && $urandom_range(0, 39) == 0) begin
                    bus.port_acc_i[p] = 1'b0;
                    bus.port_we_i[p]  = 1'b0;
                    cool[p] = 1;
                end
            end else if (want[p]) begin
                if (cool[p] > 0) begin
                    cool[p]--;
                end else begin
                    bus.port_acc_i[p] = 1'b1;
                    bus.port_we_i[p]  = ($urandom_range(0, 1) == 1);
                    len[p]       = bus.port_we_i[p] ? 1 : BURST;
                    start_cnt[p] = acks_taken[p];
                    bus.port_adr_i[32*p +: 32] = $urandom;
                    bus.port_dat_i[32*p +: 32] = $urandom;
                    bus.port_sel_i[4*p +: 4]   = 4'($urandom);
                end
            end
        end
        if (owner >= 0 && bus.port_acc_i[owner]) bus.mem_ack_i = ($urandom_range(0, 2) != 0);
        else                                      bus.mem_ack_i = ($urandom_range(0, 9) == 0);
        bus.mem_adr_i = $urandom;
        bus.mem_dat_i = $urandom;
    endtask

    task automatic cyc_n(input int n);
        repeat (n) begin
            @(negedge clk);
            if (agent_on) agent_step();
        end
    endtask

    initial begin
        int base, n0, pos;
        int rr_exp [4];
        rr_exp = '{0, 1, 2, 0};
        for (int p = 0; p < N; p++) begin
            acks_taken[p] = 0; start_cnt[p] = 0; len[p] = 0; cool[p] = 0; want[p] = 1'b0;
        end
        bus.port_adr_i = '0; bus.port_dat_i = '0; bus.port_sel_i = '0;
        bus.port_acc_i = '0; bus.port_we_i  = '0;
        bus.mem_ack_i  = 1'b0; bus.mem_adr_i = '0; bus.mem_dat_i = '0;

        chk("model_rr_a", rr_pick(2, 3'b011), 0);
        chk("model_rr_b", rr_pick(0, 3'b101), 2);
        chk("model_rr_c", rr_pick(1, 3'b001), 0);

        // reset values with busy inputs
        @(negedge clk);
        bus.port_acc_i = '1; bus.port_we_i = '1; bus.mem_ack_i = 1'b1;
        bus.port_adr_i = {N{32'hA5A5_0000}};
        #3;
        chk("rst_grant",   32'(bus.grant_o),    0);
        chk("rst_mem_acc", 32'(bus.mem_acc_o),  0);
        chk("rst_ack",     32'(bus.port_ack_o), 0);
        chk("rst_mem_adr", bus.mem_adr_o,       0);
        chk("rst_bufw_we", 32'(bus.bufw_we_o),  0);
        @(negedge clk);
        bus.port_acc_i = '0; bus.port_we_i = '0; bus.mem_ack_i = 1'b0; bus.port_adr_i = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // single 8-beat read on port 1
        @(negedge clk);
        bus.port_acc_i = 3'b010;
        #3 chk("rd_pre_grant", 32'(bus.grant_o), 0);
        @(negedge clk);
        #3 chk("rd_grant", 32'(bus.grant_o), 3'b010);
        chk("rd_mem_acc", 32'(bus.mem_acc_o), 1);
        base = acks_taken[1];
        for (int i = 0; i < BURST; i++) begin
            @(negedge clk);
            bus.mem_ack_i = 1'b1;
            bus.mem_adr_i = 32'h100 + 32'(4 * i);
            bus.mem_dat_i = $urandom;
            #3 chk("rd_ack", 32'(bus.port_ack_o), 3'b010);
            chk("rd_beat_adr", bus.port_adr_o, 32'h100 + 32'(4 * i));
        end
        @(negedge clk);
        bus.mem_ack_i = 1'b0; bus.port_acc_i = '0;
        #3 chk("rd_release_acc", 32'(bus.mem_acc_o), 0);
        @(negedge clk);
        #3 chk("rd_idle", 32'(bus.grant_o), 0);
        chk("rd_beats", 32'(acks_taken[1] - base), 8);

        // stray ack while idle
        @(negedge clk);
        bus.mem_ack_i = 1'b1;
        #3 chk("stray_ack", 32'(bus.port_ack_o), 0);
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        #3 chk("stray_bufw", 32'(bus.bufw_we_o), 0);

        // single write on port 2 and its snoop
        @(negedge clk);
        bus.port_acc_i = 3'b100; bus.port_we_i = 3'b100;
        bus.port_adr_i[64 +: 32] = 32'h2000;
        bus.port_dat_i[64 +: 32] = 32'hDEAD_BEEF;
        bus.port_sel_i[8 +: 4]   = 4'hF;
        @(negedge clk);
        bus.mem_ack_i = 1'b1;
        #3 chk("wr_ack", 32'(bus.port_ack_o), 3'b100);
        @(negedge clk);
        bus.mem_ack_i = 1'b0; bus.port_acc_i = '0; bus.port_we_i = '0;
        #3 chk("wr_snoop_we", 32'(bus.bufw_we_o), 3'b011);
        chk("wr_snoop_adr", bus.bufw_adr_o, 32'h2000);
        chk("wr_snoop_dat", bus.bufw_dat_o, 32'hDEAD_BEEF);
        chk("wr_snoop_sel", 32'(bus.bufw_sel_o), 4'hF);
        @(negedge clk);
        #3 chk("wr_snoop_pulse", 32'(bus.bufw_we_o), 0);
        chk("wr_snoop_hold", bus.bufw_adr_o, 32'h2000);

        // reset in the middle of a read burst
        @(negedge clk);
        bus.port_acc_i = 3'b011; bus.port_adr_i = {N{32'h0000_4000}};
        @(negedge clk);
        #3 chk("mb_grant", 32'(bus.grant_o), 3'b001);
        repeat (3) begin
            @(negedge clk);
            bus.mem_ack_i = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #3 chk("mb_rst_grant",   32'(bus.grant_o),    0);
        chk("mb_rst_mem_acc",    32'(bus.mem_acc_o),  0);
        chk("mb_rst_ack",        32'(bus.port_ack_o), 0);
        chk("mb_rst_mem_adr",    bus.mem_adr_o,       0);
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #3 chk("mb_after_rst", 32'(bus.grant_o), 3'b001);
        @(negedge clk);
        bus.port_acc_i = '0;
        cyc_n(2);

        // round-robin from reset, every port requesting continuously
        @(negedge clk);
        rst_n = 1'b0;
        dut_log.delete();
        for (int p = 0; p < N; p++) want[p] = 1'b1;
        gap_max = 0; allow_drop = 1'b0; agent_on = 1'b1;
        cyc_n(2);
        rst_n = 1'b1;
        for (int c = 0; c < 400 && dut_log.size() < 4; c++) cyc_n(1);
        chk("rr_count", 32'(dut_log.size() >= 4), 1);
        for (int i = 0; i < 4; i++)
            chk("rr_order", (i < dut_log.size()) ? dut_log[i] : -1, rr_exp[i]);

        // starvation: ports 0 and 1 hammer, port 2 joins late
        @(negedge clk);
        rst_n = 1'b0;
        want[2] = 1'b0;
        cyc_n(2);
        rst_n = 1'b1;
        cyc_n(40);
        want[2] = 1'b1;
        cyc_n(1);
        #3 n0 = dut_log.size();
        pos = -1;
        for (int c = 0; c < 400 && pos < 0; c++) begin
            cyc_n(1);
            #3;
            for (int i = n0; i < dut_log.size(); i++)
                if (pos < 0 && dut_log[i] == 2) pos = i;
        end
        chk("starve_found", 32'(pos >= 0), 1);
        chk("starve_bound", 32'(pos >= 0 && (pos - n0) <= N - 1), 1);

        // randomized traffic with gaps and early drops
        gap_max = 3; allow_drop = 1'b1;
        cyc_n(3000);
        for (int p = 0; p < N; p++) want[p] = 1'b0;
        cyc_n(60);
        chk("drain_idle", 32'(bus.port_acc_i), 0);
        agent_on = 1'b0;
        cyc_n(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
